// File: rtl/micro_sequencer_if.sv
// Control-store read port and datapath condition bundle for the LC-3 micro-sequencer.
// master = sequencer side; slave = control store / datapath side.
interface micro_sequencer_if #(
  parameter int AddrBusSize = 6,
  parameter int ElementSize = 52
);
  logic                   i_halt;
  logic [ElementSize-1:0] i_ctrl_word;
  logic [3:0]             i_ir_op;
  logic                   i_ir11;
  logic                   i_ben;
  logic                   i_mem_ready;
  logic                   i_psr15;
  logic                   i_int;
  logic                   i_acv;
  logic                   o_read_en;
  logic [AddrBusSize-1:0] o_read_addr;
  logic [31:0]            o_ucycles;

  modport master (
    input  i_halt, i_ctrl_word, i_ir_op, i_ir11, i_ben, i_mem_ready,
           i_psr15, i_int, i_acv,
    output o_read_en, o_read_addr, o_ucycles
  );

  modport slave (
    output i_halt, i_ctrl_word, i_ir_op, i_ir11, i_ben, i_mem_ready,
           i_psr15, i_int, i_acv,
    input  o_read_en, o_read_addr, o_ucycles
  );
endinterface

// File: rtl/micro_sequencer.sv
// LC-3 micro-sequencer: micro-address register plus IRD/COND/J next-state select.
// Define MICROSEQ_INT_EN to enable the privilege/interrupt/ACV branch conditions.
module micro_sequencer #(
  parameter int AddrBusSize = 6,
  parameter int ElementSize = 52,
  parameter int RESET_STATE = 18,
  parameter int IRD_BIT     = 51,
  parameter int COND_LSB    = 48,
  parameter int J_LSB       = 42
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  micro_sequencer_if.master    bus
);

  logic [AddrBusSize-1:0] state;
  logic                   read_en;
  logic [31:0]            ucycles;

  logic                   ird;
  logic [2:0]             cond;
  logic [5:0]             j_field;
  logic [5:0]             set_mask;
  logic [AddrBusSize-1:0] next_addr;

  assign ird     = bus.i_ctrl_word[IRD_BIT];
  assign cond    = bus.i_ctrl_word[COND_LSB +: 3];
  assign j_field = bus.i_ctrl_word[J_LSB +: 6];

  // Conditions only ever OR a single bit into J; a bit already set stays set.
  always_comb begin
    set_mask = 6'b0;
    case (cond)
      3'b001: set_mask[1] = bus.i_mem_ready;
      3'b010: set_mask[2] = bus.i_ben;
      3'b011: set_mask[0] = bus.i_ir11;
`ifdef MICROSEQ_INT_EN
      3'b100: set_mask[3] = bus.i_psr15;
      3'b101: set_mask[4] = bus.i_int;
      3'b110: set_mask[5] = bus.i_acv;
`endif
      default: set_mask = 6'b0;
    endcase

    if (ird) begin
      next_addr = AddrBusSize'({2'b00, bus.i_ir_op});
    end else begin
      next_addr = AddrBusSize'(j_field | set_mask);
    end
  end

  // read_en is low for exactly one cycle after reset; state is frozen that cycle.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state   <= AddrBusSize'(RESET_STATE);
      read_en <= 1'b0;
      ucycles <= 32'd0;
    end else begin
      read_en <= 1'b1;
      if (read_en && !bus.i_halt) begin
        state   <= next_addr;
        ucycles <= ucycles + 32'd1;
      end
    end
  end

  assign bus.o_read_addr = state;
  assign bus.o_read_en   = read_en;
  assign bus.o_ucycles   = ucycles;

  logic unused_bits;
`ifdef MICROSEQ_INT_EN
  assign unused_bits = &{1'b0, bus.i_ctrl_word[J_LSB-1:0]};
`else
  assign unused_bits = &{1'b0, bus.i_ctrl_word[J_LSB-1:0],
                         bus.i_psr15, bus.i_int, bus.i_acv};
`endif

endmodule
